// File: rtl/dpi_stream_sequencer.sv
// ---------------------------------------------------------------------------
// dpi_stream_sequencer
//
// Upstream feeder for the per-category regex matcher wrappers. Takes a tagged
// packet byte stream, maps each packet's flow tag onto one of 64 stream IDs
// through an internal fully-associative stream table, then drives the matcher
// control sequence: load_state, one gap cycle, the payload characters, and a
// final eop/enable pulse. One instance fans out to every category matcher.
//
// Optional feature: define DPI_SEQ_STATS_EN to build the saturating
// statistics counters. When undefined, pkt_cnt/new_cnt/evict_cnt are tied
// to zero and no counter logic exists.
//
// Ports
//   clk, rst              : rising-edge clock, asynchronous active-high reset
//   in_data[7:0]          : packet byte
//   in_vld / in_rdy       : byte handshake, accepted when both are high
//   in_sop / in_eop       : first / last byte of packet
//   in_err                : packet error, sampled with in_eop
//   in_tag[TAG_W-1:0]     : flow tag, valid with in_sop
//   flush                 : clear the stream table (acted on only in IDLE)
//   char_in[7:0]          : character to matchers
//   char_in_vld           : character valid
//   load_state            : one-cycle pulse per packet, restore matcher state
//   stream_id[5:0]        : stream index, held from load_state through eop
//   new_stream_id         : stream was freshly allocated, held like stream_id
//   eop / enable          : end-of-packet pulse; enable=1 commits the packet
//   pkt_cnt, new_cnt,
//   evict_cnt             : statistics counters (see DPI_SEQ_STATS_EN)
// ---------------------------------------------------------------------------
module dpi_stream_sequencer #(
   parameter int TAG_W       = 16,
   parameter int NUM_STREAMS = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_vld,
   input  logic              in_sop,
   input  logic              in_eop,
   input  logic              in_err,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              in_rdy,
   input  logic              flush,
   output logic [7:0]        char_in,
   output logic              char_in_vld,
   output logic              load_state,
   output logic [5:0]        stream_id,
   output logic              new_stream_id,
   output logic              eop,
   output logic              enable,
   output logic [31:0]       pkt_cnt,
   output logic [31:0]       new_cnt,
   output logic [15:0]       evict_cnt
);

   localparam int IDX_W = 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_LOAD,
      S_GAP,
      S_STREAM,
      S_EOP
   } state_e;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_e                 state_q;

   // Captured sop byte and packet attributes
   logic [TAG_W-1:0]       tag_q;
   logic [7:0]             sop_byte_q;
   logic                   eop_seen_q;   // last byte already accepted
   logic                   err_q;        // in_err latched with the eop byte
   logic                   flush_pend_q; // flush seen while busy

   // Stream table
   logic [TAG_W-1:0]       tag_mem_q [NUM_STREAMS];
   logic [NUM_STREAMS-1:0] valid_q;
   logic [IDX_W-1:0]       victim_q;

   // Registered outputs
   logic                   in_rdy_q;
   logic [7:0]             char_q;
   logic                   char_vld_q;
   logic                   load_state_q;
   logic [IDX_W-1:0]       sid_q;
   logic                   new_sid_q;
   logic                   eop_q;
   logic                   enable_q;

   // ------------------------------------------------------------------------
   // Table lookup (evaluated every cycle, consumed only in LOOKUP)
   // ------------------------------------------------------------------------
   logic                   hit;
   logic [IDX_W-1:0]       hit_idx;
   logic                   free_found;
   logic [IDX_W-1:0]       free_idx;
   logic [IDX_W-1:0]       sid_d;
   logic                   new_sid_d;
   logic [IDX_W-1:0]       victim_d;
   logic                   tag_we;
   logic                   evict;

   always_comb begin
      // NOTE: every signal gets a default before the loop so no path leaves
      // it unassigned, which would otherwise infer a latch.
      hit        = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      // Scan from the top down so the lowest matching index wins.
      for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
         if (valid_q[i] && (tag_mem_q[i] == tag_q)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      new_sid_d = ~hit;
      sid_d     = victim_q;
      victim_d  = victim_q;
      if (hit) begin
         sid_d = hit_idx;
      end else if (free_found) begin
         sid_d = free_idx;
      end else begin
         // Full table: replace round-robin, wrapping 63 -> 0.
         victim_d = victim_q + IDX_W'(1);
      end
   end

   assign tag_we = (state_q == S_LOOKUP) && !hit;
   assign evict  = tag_we && !free_found;

   // NOTE: the tag storage has no reset; valid_q qualifies every compare, so
   // stale contents of an invalid entry can never produce a hit.
   always_ff @(posedge clk) begin
      if (tag_we) begin
         tag_mem_q[sid_d] <= tag_q;
      end
   end

   // ------------------------------------------------------------------------
   // Control FSM with registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         tag_q        <= '0;
         sop_byte_q   <= '0;
         eop_seen_q   <= 1'b0;
         err_q        <= 1'b0;
         flush_pend_q <= 1'b0;
         valid_q      <= '0;
         victim_q     <= '0;
         in_rdy_q     <= 1'b0;
         char_q       <= '0;
         char_vld_q   <= 1'b0;
         load_state_q <= 1'b0;
         sid_q        <= '0;
         new_sid_q    <= 1'b0;
         eop_q        <= 1'b0;
         enable_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register in
         // this block sees the pre-edge value of every other one.
         load_state_q <= 1'b0;
         char_vld_q   <= 1'b0;
         eop_q        <= 1'b0;

         // A flush arriving while a packet is in flight waits for IDLE.
         if (flush && (state_q != S_IDLE)) begin
            flush_pend_q <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               in_rdy_q <= 1'b1;
               if (in_vld && in_rdy_q && in_sop) begin
                  tag_q      <= in_tag;
                  sop_byte_q <= in_data;
                  eop_seen_q <= in_eop;
                  err_q      <= in_eop & in_err;
                  in_rdy_q   <= 1'b0;
                  state_q    <= S_LOOKUP;
                  if (flush) begin
                     flush_pend_q <= 1'b1;
                  end
               end else if (flush || flush_pend_q) begin
                  valid_q      <= '0;
                  victim_q     <= '0;
                  flush_pend_q <= 1'b0;
               end
               // Non-sop bytes accepted here are dropped.
            end

            S_LOOKUP: begin
               sid_q        <= sid_d;
               new_sid_q    <= new_sid_d;
               victim_q     <= victim_d;
               if (!hit) begin
                  valid_q[sid_d] <= 1'b1;
               end
               load_state_q <= 1'b1;
               state_q      <= S_LOAD;
            end

            S_LOAD: begin
               state_q <= S_GAP;
            end

            S_GAP: begin
               // First STREAM cycle replays the captured sop byte. A
               // single-byte packet takes no further input.
               char_q     <= sop_byte_q;
               char_vld_q <= 1'b1;
               in_rdy_q   <= ~eop_seen_q;
               state_q    <= S_STREAM;
            end

            S_STREAM: begin
               if (eop_seen_q) begin
                  // Last character is on char_in this cycle; eop follows.
                  eop_q    <= 1'b1;
                  enable_q <= ~err_q;
                  in_rdy_q <= 1'b0;
                  state_q  <= S_EOP;
               end else if (in_vld && in_rdy_q) begin
                  if (in_sop) begin
                     // Protocol error: drop the byte and abort uncommitted.
                     eop_q    <= 1'b1;
                     enable_q <= 1'b0;
                     in_rdy_q <= 1'b0;
                     state_q  <= S_EOP;
                  end else begin
                     char_q     <= in_data;
                     char_vld_q <= 1'b1;
                     if (in_eop) begin
                        eop_seen_q <= 1'b1;
                        err_q      <= in_err;
                        in_rdy_q   <= 1'b0;
                     end
                  end
               end
            end

            S_EOP: begin
               enable_q <= 1'b0;
               in_rdy_q <= 1'b1;
               state_q  <= S_IDLE;
            end

            default: begin
               state_q  <= S_IDLE;
               in_rdy_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_rdy        = in_rdy_q;
   assign char_in       = char_q;
   assign char_in_vld   = char_vld_q;
   assign load_state    = load_state_q;
   assign stream_id     = sid_q;
   assign new_stream_id = new_sid_q;
   assign eop           = eop_q;
   assign enable        = enable_q;

   // ------------------------------------------------------------------------
   // Statistics
   // ------------------------------------------------------------------------
`ifdef DPI_SEQ_STATS_EN
   logic [31:0] pkt_cnt_q;
   logic [31:0] new_cnt_q;
   logic [15:0] evict_cnt_q;

   // Saturating counters, cleared only by reset (flush leaves them alone).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_cnt_q   <= '0;
         new_cnt_q   <= '0;
         evict_cnt_q <= '0;
      end else begin
         if (eop_q && (pkt_cnt_q != '1)) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
         end
         if (tag_we && (new_cnt_q != '1)) begin
            new_cnt_q <= new_cnt_q + 32'd1;
         end
         if (evict && (evict_cnt_q != '1)) begin
            evict_cnt_q <= evict_cnt_q + 16'd1;
         end
      end
   end

   assign pkt_cnt   = pkt_cnt_q;
   assign new_cnt   = new_cnt_q;
   assign evict_cnt = evict_cnt_q;
`else
   assign pkt_cnt   = '0;
   assign new_cnt   = '0;
   assign evict_cnt = '0;
`endif

endmodule
